// File: rtl/audio_stream_fx.sv
// Audio codec stream effects: swap, mute, attenuate and dithered noise add,
// pipelined as capture -> process -> write with backpressure on the output FIFO.
module audio_stream_fx #(
    parameter int          DATA_W      = 24,
    parameter int          NOISE_SHIFT = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              read_ready,
    input  logic              write_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    input  logic              mute_l,
    input  logic              mute_r,
    input  logic              swap,
    input  logic              noise_en,
    input  logic [2:0]        atten,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {S_IDLE, S_PROC, S_WRITE} state_t;

    state_t                    state_q;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [15:0]               noise_q;
    logic signed [DATA_W-1:0]  in_l_q, in_r_q;
    logic                      mute_l_q, mute_r_q, swap_q, noise_en_q;
    logic [2:0]                atten_q;
    logic [DATA_W-1:0]         wd_l_q, wd_r_q, wd_l_d, wd_r_d;
    logic [15:0]               fc_q;

    logic signed [DATA_W-1:0]  src_l, src_r, noise_s;
    logic signed [15:0]        lfsr_shifted;

    // Mute wins over everything; the noise add saturates instead of wrapping.
    function automatic logic signed [DATA_W-1:0] fx_chan(
        input logic signed [DATA_W-1:0] s,
        input logic                     mute,
        input logic [2:0]               sh,
        input logic signed [DATA_W-1:0] noise
    );
        logic signed [DATA_W-1:0] att;
        logic signed [DATA_W:0]   sum;
        att = s >>> sh;
        sum = {att[DATA_W-1], att} + {noise[DATA_W-1], noise};
        if (mute)
            return '0;
        if (sum[DATA_W] != sum[DATA_W-1])
            return sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return sum[DATA_W-1:0];
    endfunction

    always_comb begin
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        src_l        = swap_q ? in_r_q : in_l_q;
        src_r        = swap_q ? in_l_q : in_r_q;
        lfsr_shifted = $signed(noise_q) >>> NOISE_SHIFT;
        noise_s      = noise_en_q ? DATA_W'(lfsr_shifted) : '0;
        wd_l_d       = fx_chan(src_l, mute_l_q, atten_q, noise_s);
        wd_r_d       = fx_chan(src_r, mute_r_q, atten_q, noise_s);
    end

    // Strobes decode the state register so the pop/push lands in the same
    // cycle the codec reports ready; reset masks them immediately.
    assign read  = ~reset & (state_q == S_IDLE)  & read_ready;
    assign write = ~reset & (state_q == S_WRITE) & write_ready;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            noise_q    <= '0;
            in_l_q     <= '0;
            in_r_q     <= '0;
            mute_l_q   <= 1'b0;
            mute_r_q   <= 1'b0;
            swap_q     <= 1'b0;
            noise_en_q <= 1'b0;
            atten_q    <= '0;
            wd_l_q     <= '0;
            wd_r_q     <= '0;
            fc_q       <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            case (state_q)
                S_IDLE: begin
                    if (read_ready) begin
                        in_l_q     <= readdata_left;
                        in_r_q     <= readdata_right;
                        mute_l_q   <= mute_l;
                        mute_r_q   <= mute_r;
                        swap_q     <= swap;
                        noise_en_q <= noise_en;
                        atten_q    <= atten;
                        noise_q    <= lfsr_q;
                        state_q    <= S_PROC;
                    end
                end
                S_PROC: begin
                    wd_l_q  <= wd_l_d;
                    wd_r_q  <= wd_r_d;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (write_ready) begin
                        fc_q    <= fc_q + 16'd1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign writedata_left  = wd_l_q;
    assign writedata_right = wd_r_q;
    assign frame_count     = fc_q;

endmodule

// File: tb/tb_audio_stream_fx.sv
// Randomized and directed bench for audio_stream_fx against an integer-arithmetic
// frame model driven by the strobes observed on the codec interface.
module tb_audio_stream_fx;

    localparam int          DATA_W      = 24;
    localparam int          NOISE_SHIFT = 4;
    localparam logic [15:0] SEED        = 16'hACE1;

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
    logic              read_ready = 1'b0, write_ready = 1'b0;
    logic [DATA_W-1:0] readdata_left = '0, readdata_right = '0;
    logic              mute_l = 1'b0, mute_r = 1'b0, swap = 1'b0, noise_en = 1'b0;
    logic [2:0]        atten = '0;
    logic              read, write;
    logic [DATA_W-1:0] writedata_left, writedata_right;
    logic [15:0]       frame_count;

    audio_stream_fx #(
        .DATA_W     (DATA_W),
        .NOISE_SHIFT(NOISE_SHIFT),
        .LFSR_SEED  (SEED)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .read_ready     (read_ready),
        .write_ready    (write_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .mute_l         (mute_l),
        .mute_r         (mute_r),
        .swap           (swap),
        .noise_en       (noise_en),
        .atten          (atten),
        .read           (read),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .frame_count    (frame_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (((x & 16'd1) != 0) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic longint sx(input logic [DATA_W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Frame reference: plain integer arithmetic with explicit clamping.
    function automatic logic [2*DATA_W-1:0] model_frame(
        input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
        input logic ml, input logic mr, input logic sw, input logic ne,
        input logic [2:0] at, input logic [15:0] lfsr);
        longint a[2];
        longint y[2];
        longint noise, hi, lo;
        bit     m[2];
        hi    = (longint'(1) <<< (DATA_W-1)) - 1;
        lo    = -(longint'(1) <<< (DATA_W-1));
        a[0]  = sw ? sx(r) : sx(l);
        a[1]  = sw ? sx(l) : sx(r);
        m[0]  = ml;
        m[1]  = mr;
        noise = ne ? (longint'($signed(lfsr)) >>> NOISE_SHIFT) : 0;
        for (int c = 0; c < 2; c++) begin
            if (m[c]) y[c] = 0;
            else begin
                y[c] = (a[c] >>> at) + noise;
                if (y[c] > hi) y[c] = hi;
                if (y[c] < lo) y[c] = lo;
            end
        end
        return {y[1][DATA_W-1:0], y[0][DATA_W-1:0]};
    endfunction

    logic [15:0] m_lfsr = SEED;
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) m_lfsr = SEED;
        else       m_lfsr = lfsr_next(m_lfsr);
    end

    int                  cyc = 0, n_reads = 0, n_writes = 0, read_cyc = 0, write_cyc = 0;
    logic [DATA_W-1:0]   last_wl = '0, last_wr = '0;
    logic [2*DATA_W-1:0] expq[$];
    logic [2*DATA_W-1:0] e;
    logic [15:0]         m_fc = '0;
    bit                  fc_pend = 0;

    always @(negedge CLOCK_50) begin
        cyc++;
        if (reset) begin
            expq.delete();
            m_fc    = '0;
            fc_pend = 0;
        end else begin
            if (fc_pend) begin
                check("frame_count", frame_count, m_fc);
                fc_pend = 0;
            end
            if (read && write) check("read_write_overlap", 1, 0);
            if (read) begin
                if (expq.size() != 0) check("read_before_write_done", 1, 0);
                expq.push_back(model_frame(readdata_left, readdata_right, mute_l, mute_r,
                                           swap, noise_en, atten, m_lfsr));
                read_cyc = cyc;
                n_reads++;
            end
            if (write) begin
                if (expq.size() == 0) check("spurious_write", 1, 0);
                else begin
                    e = expq.pop_front();
                    check("writedata_left", writedata_left, e[DATA_W-1:0]);
                    check("writedata_right", writedata_right, e[2*DATA_W-1:DATA_W]);
                end
                check("read_to_write_gap_ge2", (cyc - read_cyc) >= 2, 1);
                last_wl   = writedata_left;
                last_wr   = writedata_right;
                write_cyc = cyc;
                n_writes++;
                m_fc++;
                fc_pend = 1;
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic scramble();
        {mute_l, mute_r, swap, noise_en} = 4'($urandom);
        atten          = 3'($urandom);
        readdata_left  = DATA_W'($urandom);
        readdata_right = DATA_W'($urandom);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              input logic ml, input logic mr, input logic sw,
                              input logic ne, input logic [2:0] at);
        int k;
        readdata_left  = l;
        readdata_right = r;
        {mute_l, mute_r, swap, noise_en} = {ml, mr, sw, ne};
        atten      = at;
        read_ready = 1'b1;
        #1;
        k = 0;
        while (!read && k < 40) begin
            @(posedge CLOCK_50);
            #3;
            k++;
        end
        check("read_seen", read, 1);
        tick();
        read_ready = 1'b0;
        scramble();
    endtask

    task automatic wait_writes(input int target, input string tag);
        int k;
        k = 0;
        while (n_writes < target && k < 60) begin
            tick();
            k++;
        end
        check(tag, n_writes >= target, 1);
    endtask

    task automatic send_noise(input bit want_neg, input logic [DATA_W-1:0] l,
                              input logic [DATA_W-1:0] r);
        bit found;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            tick();
            if (want_neg ? m_lfsr[15] : (!m_lfsr[15] && m_lfsr[14:NOISE_SHIFT] != 0))
                found = 1;
        end
        check(want_neg ? "neg_noise_found" : "pos_noise_found", found, 1);
        send_frame(l, r, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, r0;
        logic [DATA_W-1:0] snap_l, snap_r;

        // Reset state, with the codec claiming data is ready.
        read_ready  = 1'b1;
        write_ready = 1'b1;
        tick();
        tick();
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_wdl", writedata_left, 0);
        check("rst_wdr", writedata_right, 0);
        check("rst_fc", frame_count, 0);
        read_ready = 1'b0;
        reset      = 1'b0;
        tick();
        tick();
        check("idle_no_read", n_reads, 0);

        // Passthrough.
        send_frame(24'h123456, 24'hFEDCBA, 0, 0, 0, 0, 3'd0);
        wait_writes(1, "pass_done");
        check("pass_L", last_wl, 24'h123456);
        check("pass_R", last_wr, 24'hFEDCBA);
        check("pass_gap", write_cyc - read_cyc, 2);
        check("pass_fc", frame_count, 1);

        // Swap + mute left.
        send_frame(24'h000100, 24'h000200, 1, 0, 1, 0, 3'd0);
        wait_writes(2, "swapmute_done");
        check("swapmute_L", last_wl, 24'h000000);
        check("swapmute_R", last_wr, 24'h000100);

        // Attenuate.
        send_frame(24'hFFFF00, 24'h000400, 0, 0, 0, 0, 3'd3);
        wait_writes(3, "atten_done");
        check("atten_L", last_wl, 24'hFFFFE0);
        check("atten_R", last_wr, 24'h000080);

        // Saturation on both noise polarities.
        send_noise(0, 24'h7FFFFF, 24'h800000);
        wait_writes(4, "sat_pos_done");
        check("sat_pos_L", last_wl, 24'h7FFFFF);
        send_noise(1, 24'h7FFFFF, 24'h800000);
        wait_writes(5, "sat_neg_done");
        check("sat_neg_R", last_wr, 24'h800000);
        check("sat_neg_L_positive", last_wl[DATA_W-1], 0);

        // Backpressure: hold the output for 10 cycles while a new input is offered.
        write_ready = 1'b0;
        send_frame(DATA_W'($urandom), DATA_W'($urandom), 0, 0, 0, 1, 3'd1);
        tick();
        snap_l     = writedata_left;
        snap_r     = writedata_right;
        w0         = n_writes;
        r0         = n_reads;
        read_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_write_low", write, 0);
            check("bp_read_low", read, 0);
            check("bp_hold_L", writedata_left, snap_l);
            check("bp_hold_R", writedata_right, snap_r);
        end
        read_ready  = 1'b0;
        write_ready = 1'b1;
        tick();
        tick();
        tick();
        check("bp_one_write", n_writes, w0 + 1);
        check("bp_no_extra_read", n_reads, r0);

        // Reset while the frame sits in WRITE.
        write_ready = 1'b0;
        send_frame(24'h0ABCDE, 24'h054321, 0, 0, 0, 0, 3'd0);
        tick();
        w0    = n_writes;
        reset = 1'b1;
        #1;
        check("mid_rst_async_wdl", writedata_left, 0);
        check("mid_rst_async_fc", frame_count, 0);
        tick();
        check("mid_rst_read", read, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_wdl", writedata_left, 0);
        check("mid_rst_wdr", writedata_right, 0);
        check("mid_rst_fc", frame_count, 0);
        reset       = 1'b0;
        write_ready = 1'b1;
        repeat (6) tick();
        check("mid_rst_no_write", n_writes, w0);
        check("mid_rst_fc_after", frame_count, 0);

        // Randomized frames with random output backpressure.
        for (int i = 0; i < 60; i++) begin
            write_ready = 1'($urandom_range(0, 1));
            w0 = n_writes;
            send_frame(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), 3'($urandom));
            for (int k = 0; k < 60 && n_writes <= w0; k++) begin
                write_ready = ($urandom_range(0, 2) != 0);
                tick();
            end
            check("rand_frame_done", n_writes, w0 + 1);
        end
        write_ready = 1'b1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
